// File: rtl/sparc_exu_ecl_scrubctl.sv
// -----------------------------------------------------------------------------
// sparc_exu_ecl_scrubctl
//
// Background scrub sequencer for the integer register file ECC path. It walks
// every IRF entry in order. Each entry is read through the shared IRF read port
// in a cycle where the pipeline does not use that port, and the shared ECC
// checker checks the read. Three outcomes are possible:
//   - Correctable error: a correction write is requested on the ECC-fix write
//     port. A pipeline fix that is pending always wins that port.
//   - Uncorrectable error: a one-cycle report goes to the IFU error logger.
//   - No error: the walk simply moves on.
// The entry pointer survives a disable, so a re-enable resumes the walk where
// it stopped.
//
// Ports
//   clk             core clock
//   arst_l          asynchronous active-low reset
//   scrub_en        level enable for background scrubbing
//   scrub_interval  idle cycles between attempts (0 = back-to-back)
//   disable_ce      treat a correctable error as uncorrectable
//   pipe_rd_busy    pipeline owns the IRF read port this cycle
//   scrub_rd_req    scrub read request (combinational on pipe_rd_busy)
//   scrub_rd_addr   current entry pointer
//   scrub_chk_vld   checker result valid for the outstanding scrub read
//   scrub_chk_ce    correctable error flag (qualified by scrub_chk_vld)
//   scrub_chk_ue    uncorrectable error flag (qualified by scrub_chk_vld)
//   pipe_fix_req    pipeline correction pending on the write port
//   scrub_wr_req    correction write request (combinational on pipe_fix_req)
//   scrub_wr_gnt    write accepted this cycle
//   scrub_ue_m      one-cycle uncorrectable-error report pulse
//   scrub_err_reg   entry logged with the last uncorrectable error
//   scrub_ce_cnt    saturating count of corrected entries
//   scrub_busy      sequencer is not idle
// -----------------------------------------------------------------------------
module sparc_exu_ecl_scrubctl #(
  parameter int ENT_W = 8,
  parameter int NENT  = 160,
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             arst_l,
  input  logic             scrub_en,
  input  logic [INT_W-1:0] scrub_interval,
  input  logic             disable_ce,
  input  logic             pipe_rd_busy,
  output logic             scrub_rd_req,
  output logic [ENT_W-1:0] scrub_rd_addr,
  input  logic             scrub_chk_vld,
  input  logic             scrub_chk_ce,
  input  logic             scrub_chk_ue,
  input  logic             pipe_fix_req,
  output logic             scrub_wr_req,
  input  logic             scrub_wr_gnt,
  output logic             scrub_ue_m,
  output logic [7:0]       scrub_err_reg,
  output logic [7:0]       scrub_ce_cnt,
  output logic             scrub_busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RD   = 3'd2,
    S_CHK  = 3'd3,
    S_WR   = 3'd4
  } state_e;

  // A CE with correction disabled escalates to a UE, exactly as the pipeline
  // path treats it.
  function automatic logic eff_ue_f(input logic ce, input logic ue, input logic dis);
    eff_ue_f = ue | (ce & dis);
  endfunction

  // A simultaneous CE+UE is a UE only, so it never produces a write.
  function automatic logic eff_ce_f(input logic ce, input logic ue, input logic dis);
    eff_ce_f = ce & ~dis & ~ue;
  endfunction

  // Entry pointer successor. The walk wraps from NENT-1 back to 0.
  function automatic logic [ENT_W-1:0] ptr_next_f(input logic [ENT_W-1:0] p);
    if (p == ENT_W'(NENT - 1)) begin
      ptr_next_f = {ENT_W{1'b0}};
    end else begin
      ptr_next_f = p + {{(ENT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e           state_q, state_d;
  logic [ENT_W-1:0] ptr_q, ptr_d;
  logic [INT_W-1:0] cnt_q, cnt_d;
  logic             ue_q, ue_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       ce_cnt_q, ce_cnt_d;

  logic chk_ue_s;
  logic chk_ce_s;
  logic rd_req_s;
  logic wr_req_s;

  // The read is issued only while enabled. An RD state that is abandoned
  // because the enable dropped therefore never leaves a checker result with no
  // CHK state to consume it.
  assign rd_req_s = (state_q == S_RD) & ~pipe_rd_busy & scrub_en;
  assign wr_req_s = (state_q == S_WR) & ~pipe_fix_req;
  assign chk_ue_s = eff_ue_f(scrub_chk_ce, scrub_chk_ue, disable_ce);
  assign chk_ce_s = eff_ce_f(scrub_chk_ce, scrub_chk_ue, disable_ce);

  assign scrub_rd_req  = rd_req_s;
  assign scrub_wr_req  = wr_req_s;
  assign scrub_rd_addr = ptr_q;
  assign scrub_ue_m    = ue_q;
  assign scrub_err_reg = err_q;
  assign scrub_ce_cnt  = ce_cnt_q;
  assign scrub_busy    = (state_q != S_IDLE);

  // Next-state, pointer, interval counter and reporting logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ue_d     = 1'b0;
    err_d    = err_q;
    ce_cnt_d = ce_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (scrub_en) begin
          cnt_d   = scrub_interval;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // The enable check comes first, so a drop on the last count still idles.
        if (!scrub_en) begin
          state_d = S_IDLE;
        end else if (cnt_q == {INT_W{1'b0}}) begin
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q - {{(INT_W-1){1'b0}}, 1'b1};
        end
      end
      S_RD: begin
        if (!scrub_en) begin
          state_d = S_IDLE;
        end else if (!pipe_rd_busy) begin
          state_d = S_CHK;
        end else begin
          state_d = S_RD;
        end
      end
      S_CHK: begin
        // Once the read is out, the entry always completes regardless of the enable.
        if (scrub_chk_vld) begin
          if (chk_ue_s) begin
            ue_d    = 1'b1;
            err_d   = 8'(ptr_q);
            ptr_d   = ptr_next_f(ptr_q);
            cnt_d   = scrub_interval;
            state_d = scrub_en ? S_WAIT : S_IDLE;
          end else if (chk_ce_s) begin
            state_d = S_WR;
          end else begin
            ptr_d   = ptr_next_f(ptr_q);
            cnt_d   = scrub_interval;
            state_d = scrub_en ? S_WAIT : S_IDLE;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      S_WR: begin
        if (wr_req_s && scrub_wr_gnt) begin
          if (ce_cnt_q != 8'hFF) begin
            ce_cnt_d = ce_cnt_q + 8'd1;
          end else begin
            ce_cnt_d = ce_cnt_q;
          end
          ptr_d   = ptr_next_f(ptr_q);
          cnt_d   = scrub_interval;
          state_d = scrub_en ? S_WAIT : S_IDLE;
        end else begin
          state_d = S_WR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q  <= S_IDLE;
      ptr_q    <= {ENT_W{1'b0}};
      cnt_q    <= {INT_W{1'b0}};
      ue_q     <= 1'b0;
      err_q    <= 8'h00;
      ce_cnt_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ue_q     <= ue_d;
      err_q    <= err_d;
      ce_cnt_q <= ce_cnt_d;
    end
  end

endmodule

// File: tb/tb_sparc_exu_ecl_scrubctl.sv
// -----------------------------------------------------------------------------
// Testbench for sparc_exu_ecl_scrubctl.
// The bench acts as the pipeline and as the ECC checker. A transaction model
// tracks the walk with a plain integer pointer modulo NENT, a saturating CE
// count, and the last UE entry. Every cycle is checked against the timing of
// each phase (interval wait, read, check, write).
// -----------------------------------------------------------------------------
module tb_sparc_exu_ecl_scrubctl;
  localparam int ENT_W = 8;
  localparam int NENT  = 160;
  localparam int INT_W = 16;

  logic             clk = 1'b0;
  logic             arst_l;
  logic             scrub_en;
  logic [INT_W-1:0] scrub_interval;
  logic             disable_ce;
  logic             pipe_rd_busy;
  logic             scrub_rd_req;
  logic [ENT_W-1:0] scrub_rd_addr;
  logic             scrub_chk_vld;
  logic             scrub_chk_ce;
  logic             scrub_chk_ue;
  logic             pipe_fix_req;
  logic             scrub_wr_req;
  logic             scrub_wr_gnt;
  logic             scrub_ue_m;
  logic [7:0]       scrub_err_reg;
  logic [7:0]       scrub_ce_cnt;
  logic             scrub_busy;

  int n_vec = 0;
  int n_err = 0;
  int exp_ptr = 0;
  int exp_cnt = 0;
  int exp_err = 0;
  int cur_iv  = 0;
  bit pend_ue = 1'b0;

  always #5 clk = ~clk;

  sparc_exu_ecl_scrubctl #(.ENT_W(ENT_W), .NENT(NENT), .INT_W(INT_W)) dut (
    .clk(clk), .arst_l(arst_l), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
    .disable_ce(disable_ce), .pipe_rd_busy(pipe_rd_busy), .scrub_rd_req(scrub_rd_req),
    .scrub_rd_addr(scrub_rd_addr), .scrub_chk_vld(scrub_chk_vld), .scrub_chk_ce(scrub_chk_ce),
    .scrub_chk_ue(scrub_chk_ue), .pipe_fix_req(pipe_fix_req), .scrub_wr_req(scrub_wr_req),
    .scrub_wr_gnt(scrub_wr_gnt), .scrub_ue_m(scrub_ue_m), .scrub_err_reg(scrub_err_reg),
    .scrub_ce_cnt(scrub_ce_cnt), .scrub_busy(scrub_busy)
  );

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t model_ptr=%0d)", tag, obs, exp, $time, exp_ptr);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    scrub_chk_vld = 1'b0;
    scrub_chk_ce  = 1'b0;
    scrub_chk_ue  = 1'b0;
    scrub_wr_gnt  = 1'b0;
    pipe_fix_req  = 1'b0;
    pipe_rd_busy  = 1'b0;
  endtask

  // Noise on inputs that must be ignored in the current phase.
  task automatic junk();
    scrub_chk_vld = 1'($urandom_range(0, 1));
    scrub_chk_ce  = 1'($urandom_range(0, 1));
    scrub_chk_ue  = 1'($urandom_range(0, 1));
    scrub_wr_gnt  = 1'($urandom_range(0, 1));
    pipe_fix_req  = 1'($urandom_range(0, 1));
    pipe_rd_busy  = 1'($urandom_range(0, 1));
    disable_ce    = 1'($urandom_range(0, 1));
  endtask

  // One IDLE cycle with the enable raised; the next cycle is the first WAIT cycle.
  task automatic restart(input int iv);
    cur_iv = iv;
    scrub_interval = INT_W'(iv);
    quiet();
    scrub_en = 1'b1;
    settle();
    chk_eq("idle_busy",   int'(scrub_busy),    0);
    chk_eq("idle_rd_req", int'(scrub_rd_req),  0);
    chk_eq("idle_wr_req", int'(scrub_wr_req),  0);
    chk_eq("idle_ue_m",   int'(scrub_ue_m),    int'(pend_ue));
    chk_eq("idle_err",    int'(scrub_err_reg), exp_err);
    chk_eq("idle_ce_cnt", int'(scrub_ce_cnt),  exp_cnt);
    chk_eq("idle_addr",   int'(scrub_rd_addr), exp_ptr);
    pend_ue = 1'b0;
    tick();
  endtask

  // One entry, starting in its first WAIT cycle.
  // kind: 0 clean, 1 CE, 2 UE, 3 CE+UE, 4 CE with disable_ce.
  // drop: 0 none, 1 enable low in WAIT, 2 in RD, 3 from CHK on.
  task automatic do_entry(input int kind, input int nbusy, input int nfix, input int ngnt,
                          input int vdly, input int drop, input bit rst_wr);
    int dk;
    bit ce, ue, dis, eff_ue, eff_ce;
    dk = (drop == 1) ? int'($urandom_range(0, cur_iv)) : -1;
    for (int k = 0; k <= cur_iv; k++) begin
      junk();
      scrub_en = (k != dk);
      settle();
      chk_eq("wait_busy",   int'(scrub_busy),    1);
      chk_eq("wait_rd_req", int'(scrub_rd_req),  0);
      chk_eq("wait_wr_req", int'(scrub_wr_req),  0);
      chk_eq("wait_addr",   int'(scrub_rd_addr), exp_ptr);
      if (k == 0) begin
        chk_eq("ue_pulse",  int'(scrub_ue_m),    int'(pend_ue));
        chk_eq("err_reg",   int'(scrub_err_reg), exp_err);
        chk_eq("ce_cnt",    int'(scrub_ce_cnt),  exp_cnt);
        pend_ue = 1'b0;
      end else begin
        chk_eq("wait_ue_m", int'(scrub_ue_m),    0);
      end
      tick();
      if (k == dk) begin
        quiet();
        return;
      end
    end
    // Read phase, with optional port contention.
    quiet();
    scrub_en = 1'b1;
    for (int b = 0; b < nbusy; b++) begin
      pipe_rd_busy = 1'b1;
      pipe_fix_req = 1'($urandom_range(0, 1));
      settle();
      chk_eq("rd_blocked", int'(scrub_rd_req),  0);
      chk_eq("rd_addr",    int'(scrub_rd_addr), exp_ptr);
      chk_eq("rd_busy",    int'(scrub_busy),    1);
      chk_eq("rd_ue_m",    int'(scrub_ue_m),    0);
      tick();
    end
    quiet();
    scrub_en = (drop != 2);
    settle();
    chk_eq("rd_req",  int'(scrub_rd_req),  (drop != 2) ? 1 : 0);
    chk_eq("rd_addr", int'(scrub_rd_addr), exp_ptr);
    chk_eq("rd_busy", int'(scrub_busy),    1);
    chk_eq("rd_ue_m", int'(scrub_ue_m),    0);
    tick();
    if (drop == 2) begin
      return;
    end
    // Check phase.
    case (kind)
      0:       begin ce = 1'b0; ue = 1'b0; dis = 1'($urandom_range(0, 1)); end
      1:       begin ce = 1'b1; ue = 1'b0; dis = 1'b0; end
      2:       begin ce = 1'b0; ue = 1'b1; dis = 1'($urandom_range(0, 1)); end
      3:       begin ce = 1'b1; ue = 1'b1; dis = 1'($urandom_range(0, 1)); end
      default: begin ce = 1'b1; ue = 1'b0; dis = 1'b1; end
    endcase
    if (drop == 3) scrub_en = 1'b0;
    for (int d = 0; d < vdly; d++) begin
      scrub_chk_vld = 1'b0;
      scrub_chk_ce  = 1'($urandom_range(0, 1));
      scrub_chk_ue  = 1'($urandom_range(0, 1));
      disable_ce    = 1'($urandom_range(0, 1));
      pipe_rd_busy  = 1'($urandom_range(0, 1));
      settle();
      chk_eq("chk_rd_req", int'(scrub_rd_req),  0);
      chk_eq("chk_busy",   int'(scrub_busy),    1);
      chk_eq("chk_ue_m",   int'(scrub_ue_m),    0);
      chk_eq("chk_addr",   int'(scrub_rd_addr), exp_ptr);
      tick();
    end
    scrub_chk_vld = 1'b1;
    scrub_chk_ce  = ce;
    scrub_chk_ue  = ue;
    disable_ce    = dis;
    pipe_rd_busy  = 1'($urandom_range(0, 1));
    settle();
    chk_eq("vld_rd_req", int'(scrub_rd_req),  0);
    chk_eq("vld_busy",   int'(scrub_busy),    1);
    chk_eq("vld_addr",   int'(scrub_rd_addr), exp_ptr);
    tick();
    quiet();
    eff_ue = ue | (ce & dis);
    eff_ce = ce & ~dis & ~ue;
    if (!eff_ce) begin
      if (eff_ue) exp_err = exp_ptr;
      exp_ptr = (exp_ptr + 1) % NENT;
      pend_ue = eff_ue;
      return;
    end
    // Correction write phase: nfix cycles of pipeline priority, then ngnt
    // cycles of waiting for the grant, then the grant.
    for (int c = 0; c <= nfix + ngnt; c++) begin
      pipe_fix_req  = (c < nfix);
      scrub_wr_gnt  = (c < nfix) ? 1'($urandom_range(0, 1)) : (c == nfix + ngnt);
      scrub_chk_vld = 1'($urandom_range(0, 1));
      scrub_chk_ue  = 1'($urandom_range(0, 1));
      pipe_rd_busy  = 1'($urandom_range(0, 1));
      settle();
      chk_eq("wr_req",    int'(scrub_wr_req),  (c >= nfix) ? 1 : 0);
      chk_eq("wr_rd_req", int'(scrub_rd_req),  0);
      chk_eq("wr_busy",   int'(scrub_busy),    1);
      chk_eq("wr_ue_m",   int'(scrub_ue_m),    0);
      chk_eq("wr_addr",   int'(scrub_rd_addr), exp_ptr);
      chk_eq("wr_ce_cnt", int'(scrub_ce_cnt),  exp_cnt);
      if (rst_wr && c == nfix) begin
        #1 arst_l = 1'b0;
        #1;
        chk_eq("rst_wr_req",  int'(scrub_wr_req),  0);
        chk_eq("rst_rd_req",  int'(scrub_rd_req),  0);
        chk_eq("rst_ue_m",    int'(scrub_ue_m),    0);
        chk_eq("rst_busy",    int'(scrub_busy),    0);
        chk_eq("rst_err",     int'(scrub_err_reg), 0);
        chk_eq("rst_ce_cnt",  int'(scrub_ce_cnt),  0);
        chk_eq("rst_addr",    int'(scrub_rd_addr), 0);
        exp_ptr = 0;
        exp_cnt = 0;
        exp_err = 0;
        pend_ue = 1'b0;
        @(posedge clk);
        #1;
        arst_l = 1'b1;
        quiet();
        scrub_en = 1'b0;
        return;
      end
      tick();
    end
    quiet();
    if (exp_cnt < 255) exp_cnt++;
    exp_ptr = (exp_ptr + 1) % NENT;
    pend_ue = 1'b0;
  endtask

  initial begin
    int n, r, kind;
    arst_l = 1'b0;
    scrub_en = 1'b0;
    scrub_interval = '0;
    disable_ce = 1'b0;
    quiet();
    #2;
    chk_eq("reset_rd_req", int'(scrub_rd_req),  0);
    chk_eq("reset_wr_req", int'(scrub_wr_req),  0);
    chk_eq("reset_ue_m",   int'(scrub_ue_m),    0);
    chk_eq("reset_busy",   int'(scrub_busy),    0);
    chk_eq("reset_err",    int'(scrub_err_reg), 0);
    chk_eq("reset_ce_cnt", int'(scrub_ce_cnt),  0);
    chk_eq("reset_addr",   int'(scrub_rd_addr), 0);
    @(posedge clk);
    #1;
    arst_l = 1'b1;

    // Clean back-to-back walk through the wrap.
    restart(0);
    for (int i = 0; i < NENT + 1; i++) do_entry(0, 0, 0, 0, 0, 0, 1'b0);
    // Read-port contention for 5 cycles.
    do_entry(0, 5, 0, 0, 0, 0, 1'b0);
    // CE at 0x2A, with the pipeline holding the write port for 3 cycles.
    while (exp_ptr != 8'h2A) do_entry(0, 0, 0, 0, 0, 0, 1'b0);
    do_entry(1, 0, 3, 0, 1, 0, 1'b0);
    // UE, CE+UE and CE with disable_ce, starting at 0x13.
    while (exp_ptr != 8'h13) do_entry(0, 0, 0, 0, 0, 0, 1'b0);
    do_entry(2, 0, 0, 0, 0, 0, 1'b0);
    do_entry(3, 0, 0, 0, 0, 0, 1'b0);
    do_entry(4, 0, 0, 0, 0, 0, 1'b0);
    do_entry(0, 0, 0, 0, 0, 1, 1'b0);
    // Enable dropped during CHK on a UE entry, with a nonzero interval.
    restart(2);
    do_entry(2, 1, 0, 0, 2, 3, 1'b0);

    // Randomised phases, each ending with the enable dropped somewhere.
    for (int p = 0; p < 30; p++) begin
      restart(int'($urandom_range(0, 3)));
      n = int'($urandom_range(1, 8));
      for (int e = 0; e < n; e++) begin
        r = int'($urandom_range(0, 9));
        kind = (r < 4) ? 0 : (r < 6) ? 1 : (r < 7) ? 2 : (r < 8) ? 3 : 4;
        do_entry(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 (e == n - 1) ? int'($urandom_range(1, 3)) : 0, 1'b0);
      end
    end

    // Enough corrections to saturate the CE counter.
    restart(0);
    for (int i = 0; i < 260; i++) do_entry(1, 0, 0, 0, 0, 0, 1'b0);
    do_entry(0, 0, 0, 0, 0, 1, 1'b0);

    // Asynchronous reset while a correction write is being requested.
    restart(0);
    do_entry(1, 0, 1, 1, 0, 0, 1'b1);
    restart(0);
    do_entry(0, 0, 0, 0, 0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
